// File: rtl/mux_n_1_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux_scan_pkg
// Purpose : Shared definitions for the mux_n_1_scan selector: mode encoding,
//           scan FSM state type and an elaboration-time clog2 helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAN   = 2'd1,
    S_DWELL = 2'd2
  } state_e;

  // Ceiling log2, usable in parameter expressions. clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_n_1_scan_rr_next_ch.sv
`default_nettype none
// ============================================================================
// Module  : rr_next_ch
// Purpose : Combinational round-robin search. Returns the first set mask bit
//           strictly after i_cur, searching upward and wrapping N_CH-1 -> 0.
//           If i_cur is the only set bit, i_cur itself is returned.
// Ports   : i_cur        current channel index
//           i_mask       channel participation mask (1 = eligible)
//           o_nxt        next eligible index (i_cur when none is eligible)
//           o_none_valid 1 when the mask is all zeros
// Revision: 1.0 - initial release
// ============================================================================
module rr_next_ch
  import mux_scan_pkg::*;
#(
  parameter  int N_CH  = 8,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic [SEL_W-1:0] i_cur,
  input  logic [N_CH-1:0]  i_mask,
  output logic [SEL_W-1:0] o_nxt,
  output logic             o_none_valid
);

  // One extra bit so cur + 1 + offset (at most 2*N_CH-1) never overflows.
  localparam int IDX_W = SEL_W + 1;

  logic [2*N_CH-1:0] w_dbl;
  logic [N_CH-1:0]   w_rot;
  logic [IDX_W-1:0]  w_shift;
  logic [IDX_W-1:0]  w_pos;
  logic [IDX_W-1:0]  w_sum;
  logic              w_found;

  // Rotate so that bit 0 of w_rot is channel cur+1; the doubled mask makes
  // the wrap-around free.
  assign w_dbl   = {i_mask, i_mask};
  assign w_shift = IDX_W'(i_cur) + IDX_W'(1);
  assign w_rot   = N_CH'(w_dbl >> w_shift);

  // Lowest set bit of the rotated mask = nearest eligible channel upward.
  always_comb begin
    w_pos   = '0;
    w_found = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_pos   = IDX_W'(k);
        w_found = 1'b1;
      end
    end
  end

  // Un-rotate back to an absolute channel index.
  assign w_sum = w_shift + w_pos;

  always_comb begin
    o_nxt = i_cur;
    if (w_found) begin
      if (w_sum >= IDX_W'(N_CH)) begin
        o_nxt = SEL_W'(w_sum - IDX_W'(N_CH));
      end else begin
        o_nxt = SEL_W'(w_sum);
      end
    end
  end

  assign o_none_valid = ~|i_mask;

endmodule
`default_nettype wire

// File: rtl/mux_n_1_scan.sv
`default_nettype none
// ============================================================================
// Module  : mux_n_1_scan
// Purpose : Registered N_CH:1 multiplexer with manual select and a
//           round-robin auto-scan mode that dwells DWELL cycles on each
//           unmasked channel. One cycle latency from inputs to o_f.
// Ports   : i_clk       rising-edge clock
//           i_rst       synchronous active-high reset
//           i_en        global enable (0: o_f forced to 0, scan frozen)
//           i_mode      0 = manual, 1 = auto-scan
//           i_sel_code  manual channel index
//           i_ch_mask   per-channel participation (masked channel outputs 0)
//           i_data      packed channel data, channel k at [k*W +: W]
//           o_f         registered selected data
//           o_ch        registered index of the channel on o_f
//           o_ch_chg    one-cycle pulse coincident with o_ch changing
// Revision: 1.0 - initial release
// ============================================================================
module mux_n_1_scan
  import mux_scan_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int W     = 2,
  parameter  int DWELL = 4,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic [SEL_W-1:0]  i_sel_code,
  input  logic [N_CH-1:0]   i_ch_mask,
  input  logic [N_CH*W-1:0] i_data,
  output logic [W-1:0]      o_f,
  output logic [SEL_W-1:0]  o_ch,
  output logic              o_ch_chg
);

  localparam int               CNT_W    = clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [W-1:0]     f_q, f_d;
  logic             chg_q, chg_d;
  logic             drive;

  logic [W-1:0]     w_ch_data [N_CH];
  logic [SEL_W-1:0] w_rr_nxt;
  logic             w_none_valid;
  logic             w_sel_ok;

  // Unpack the flat data bus into an indexable array.
  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign w_ch_data[k] = i_data[k*W +: W];
  end

  rr_next_ch #(
    .N_CH (N_CH)
  ) u_rr_next_ch (
    .i_cur        (ch_q),
    .i_mask       (i_ch_mask),
    .o_nxt        (w_rr_nxt),
    .o_none_valid (w_none_valid)
  );

  // Only meaningful for non-power-of-2 N_CH, where the select field can
  // encode indices that have no channel behind them.
  assign w_sel_ok = ({1'b0, i_sel_code} < (SEL_W + 1)'(N_CH));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      f_q     <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      f_q     <= f_d;
      chg_q   <= chg_d;
    end
  end

  always_comb begin
    // Defaults describe the disabled cycle: everything holds, output zero.
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    f_d     = '0;
    chg_d   = 1'b0;
    drive   = 1'b0;

    if (i_en) begin
      unique case (i_mode)
        MODE_MAN: begin
          state_d = S_MAN;
          cnt_d   = '0;
          if (w_sel_ok) begin
            ch_d  = i_sel_code;
            drive = i_ch_mask[i_sel_code];
          end
        end

        MODE_SCAN: begin
          if (w_none_valid) begin
            // Nothing to scan: park on the current channel, output zero.
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_DWELL;
            if (state_q != S_DWELL) begin
              // Entering the scan: start a fresh dwell on the current
              // channel, unless it is masked, in which case move on now.
              cnt_d = '0;
              if (!i_ch_mask[ch_q]) begin
                ch_d = w_rr_nxt;
              end
            end else if (!i_ch_mask[ch_q] || (cnt_q == CNT_LAST)) begin
              // Dwell expired, or the channel was masked under us.
              ch_d  = w_rr_nxt;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            drive = i_ch_mask[ch_d];
          end
        end

        default: begin
          state_d = state_q;
        end
      endcase

      if (drive) begin
        f_d = w_ch_data[ch_d];
      end
      chg_d = (ch_d != ch_q);
    end
  end

  assign o_f      = f_q;
  assign o_ch     = ch_q;
  assign o_ch_chg = chg_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_n_1_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_n_1_scan
// Purpose : Self-checking bench for mux_n_1_scan. Two instances: the default
//           8-channel / DWELL=4 build and a 5-channel / DWELL=1 build that
//           exercises out-of-range select codes and per-cycle advancing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_n_1_scan;

  logic clk;

  // Instance 1: N_CH=8, W=2, DWELL=4
  logic        rst, en, mode;
  logic [2:0]  sel;
  logic [7:0]  mask;
  logic [15:0] data;
  logic [1:0]  f1;
  logic [2:0]  ch1;
  logic        chg1;

  // Instance 2: N_CH=5, W=3, DWELL=1
  logic        rst2, en2, mode2;
  logic [2:0]  sel2;
  logic [4:0]  mask2;
  logic [14:0] data2;
  logic [2:0]  f2;
  logic [2:0]  ch2;
  logic        chg2;

  int total = 0;
  int bad   = 0;

  mux_n_1_scan #(.N_CH(8), .W(2), .DWELL(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_sel_code(sel),
    .i_ch_mask(mask), .i_data(data), .o_f(f1), .o_ch(ch1), .o_ch_chg(chg1)
  );

  mux_n_1_scan #(.N_CH(5), .W(3), .DWELL(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst2), .i_en(en2), .i_mode(mode2), .i_sel_code(sel2),
    .i_ch_mask(mask2), .i_data(data2), .o_f(f2), .o_ch(ch2), .o_ch_chg(chg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int ch;      // channel on the output
    int left;    // enabled scan cycles still to spend before advancing
    bit active;  // a dwell is in progress
    int f;
    bit chg;
  } mstate_t;

  mstate_t m1, m2;

  function automatic int field(input logic [63:0] d, input int k, input int w);
    return int'((d >> (k * w)) & ((64'd1 << w) - 64'd1));
  endfunction

  function automatic bit mbit(input int m, input int k);
    return bit'((m >> k) & 1);
  endfunction

  function automatic int nextch(input int cur, input int m, input int n);
    for (int k = 1; k <= n; k++) begin
      if (mbit(m, (cur + k) % n)) return (cur + k) % n;
    end
    return cur;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int n, input int dw,
                                    input int w, input bit r, input bit e,
                                    input bit md, input int sl, input int m,
                                    input logic [63:0] d);
    mstate_t o;
    int nw;
    o = s;
    if (r) begin
      o = '{default: 0};
      return o;
    end
    if (!e) begin
      o.f   = 0;
      o.chg = 0;
      return o;
    end
    nw  = s.ch;
    o.f = 0;
    if (!md) begin
      o.active = 0;
      if (sl < n) begin
        nw = sl;
        if (mbit(m, sl)) o.f = field(d, sl, w);
      end
    end else if (m == 0) begin
      o.active = 0;
    end else begin
      if (!s.active || !mbit(m, s.ch)) begin
        nw       = (!s.active && mbit(m, s.ch)) ? s.ch : nextch(s.ch, m, n);
        o.left   = dw - 1;
        o.active = 1;
      end else if (s.left == 0) begin
        nw     = nextch(s.ch, m, n);
        o.left = dw - 1;
      end else begin
        o.left = s.left - 1;
      end
      o.f = field(d, nw, w);
    end
    o.chg = (nw != s.ch);
    o.ch  = nw;
    return o;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock; both models consume the inputs the DUTs sampled.
  task automatic tick();
    @(posedge clk);
    m1 = mstep(m1, 8, 4, 2, rst, en, mode, int'(sel), int'(mask), 64'(data));
    m2 = mstep(m2, 5, 1, 3, rst2, en2, mode2, int'(sel2), int'(mask2), 64'(data2));
    #1;
    chk("m1_f", 32'(f1), m1.f);
    chk("m1_ch", 32'(ch1), m1.ch);
    chk("m1_chg", 32'(chg1), 32'(m1.chg));
    chk("m2_f", 32'(f2), m2.f);
    chk("m2_ch", 32'(ch2), m2.ch);
    chk("m2_chg", 32'(chg2), 32'(m2.chg));
  endtask

  task automatic expect1(input string nm, input int ef, input int ech, input int echg);
    chk({nm, "_f"}, 32'(f1), ef);
    chk({nm, "_ch"}, 32'(ch1), ech);
    chk({nm, "_chg"}, 32'(chg1), echg);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit         rst;
    bit         en;
    bit         mode;
    logic [2:0] sel;
    logic [7:0] mask;
    int         ef;
    int         ech;
    int         echg;
  } vec_t;

  vec_t vecs[11];

  localparam logic [15:0] DATA_FIX = 16'h99F9; // ch0..7 = 1,2,3,3,1,2,1,2

  initial begin
    int found;
    int seq_ch[13];

    vecs[0]  = '{1, 1, 0, 3'd5, 8'hFF, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 3'd5, 8'hFF, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 3'd5, 8'hFF, 2, 5, 1};
    vecs[3]  = '{0, 1, 0, 3'd5, 8'hFF, 2, 5, 0};
    vecs[4]  = '{0, 1, 0, 3'd3, 8'hFF, 3, 3, 1};
    vecs[5]  = '{0, 0, 0, 3'd3, 8'hFF, 0, 3, 0};
    vecs[6]  = '{0, 0, 0, 3'd3, 8'hFF, 0, 3, 0};
    vecs[7]  = '{0, 0, 0, 3'd3, 8'hFF, 0, 3, 0};
    vecs[8]  = '{0, 1, 0, 3'd3, 8'hF7, 0, 3, 0};
    vecs[9]  = '{0, 1, 0, 3'd3, 8'hFF, 3, 3, 0};
    vecs[10] = '{0, 1, 0, 3'd6, 8'hFF, 1, 6, 1};

    m1 = '{default: 0};
    m2 = '{default: 0};
    rst = 1'b1; en = 1'b1; mode = 1'b0; sel = '0; mask = 8'hFF; data = DATA_FIX;
    rst2 = 1'b1; en2 = 1'b1; mode2 = 1'b0; sel2 = '0; mask2 = 5'h1F; data2 = '0;

    for (int i = 0; i < 11; i++) begin
      rst  = vecs[i].rst;
      en   = vecs[i].en;
      mode = vecs[i].mode;
      sel  = vecs[i].sel;
      mask = vecs[i].mask;
      tick();
      expect1($sformatf("vec%0d", i), vecs[i].ef, vecs[i].ech, vecs[i].echg);
    end

    // Sparse-mask scan from channel 0.
    rst = 1'b1;
    tick();
    expect1("rst_scan", 0, 0, 0);
    rst  = 1'b0;
    mode = 1'b1;
    mask = 8'b1000_0101;
    seq_ch = '{0, 0, 0, 0, 2, 2, 2, 2, 7, 7, 7, 7, 0};
    for (int i = 0; i < 13; i++) begin
      tick();
      expect1($sformatf("scan%0d", i), field(64'(DATA_FIX), seq_ch[i], 2),
              seq_ch[i], (i == 4 || i == 8 || i == 12) ? 1 : 0);
    end

    // Mask ch2 two cycles into its dwell.
    repeat (4) tick();
    expect1("on_ch2", 3, 2, 1);
    repeat (2) tick();
    mask = 8'b1000_0001;
    tick();
    expect1("mask_ch2", 2, 7, 1);

    // Empty mask: idle, hold, no pulses.
    mask = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect1($sformatf("idle%0d", i), 0, 7, 0);
    end

    // Single channel.
    mask = 8'h10;
    tick();
    expect1("single", 1, 4, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect1($sformatf("single_hold%0d", i), 1, 4, 0);
    end

    // Pause mid-dwell on ch2 at counter 2.
    mask  = 8'b1000_0101;
    found = 0;
    for (int i = 0; i < 24 && found == 0; i++) begin
      tick();
      if (m1.ch == 2 && m1.chg) found = 1;
    end
    chk("reach_ch2", 32'(found), 1);
    repeat (2) tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect1($sformatf("pause%0d", i), 0, 2, 0);
    end
    en = 1'b1;
    tick();
    expect1("resume0", 3, 2, 0);
    tick();
    expect1("resume1", 2, 7, 1);

    // Reset mid-dwell.
    tick();
    rst = 1'b1;
    tick();
    expect1("rst_mid", 0, 0, 0);
    rst = 1'b0;

    // Mode switches.
    repeat (2) tick();
    mode = 1'b0;
    sel  = 3'd6;
    tick();
    expect1("to_man", 0, 6, 1);
    mask = 8'hFF;
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect1($sformatf("to_scan%0d", i), 1, 6, 0);
    end
    tick();
    expect1("to_scan_adv", 2, 7, 1);

    // Randomised run on both instances.
    rst2 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       mask = 8'h00;
          1:       mask = 8'(1 << $urandom_range(0, 7));
          default: mask = 8'($urandom);
        endcase
      end
      sel  = 3'($urandom_range(0, 7));
      data = 16'($urandom);

      rst2 = ($urandom_range(0, 99) == 0);
      en2  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) mode2 = ~mode2;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       mask2 = 5'h00;
          1:       mask2 = 5'(1 << $urandom_range(0, 4));
          default: mask2 = 5'($urandom);
        endcase
      end
      sel2  = 3'($urandom_range(0, 7));
      data2 = 15'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
